// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - data-port request/response bundle; DMEM_BYTE_EN_EN adds byte enables
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]  be;
`endif
  logic [31:0] rd;
  logic        ack;
  logic        err;
  logic        busy;

`ifdef DMEM_BYTE_EN_EN
  modport master (output req, we, addr, wd, be, input rd, ack, err, busy);
  modport slave  (input req, we, addr, wd, be, output rd, ack, err, busy);
`else
  modport master (output req, we, addr, wd, input rd, ack, err, busy);
  modport slave  (input req, we, addr, wd, output rd, ack, err, busy);
`endif
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-port responder with programmable wait states; optional DMEM_BYTE_EN_EN
module dmem_responder #(
  parameter int ADDR_W_WORDS = 8,
  parameter int WAIT_STATES  = 2,
  parameter int CNT_W        = 4
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W_WORDS;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    lat_we;
  logic [ADDR_W_WORDS-1:0] lat_idx;
  logic [31:0]             lat_wd;
  logic [31:0]             rd_q;
  logic                    err_q;
  logic                    busy_q;
  logic [31:0]             mem [DEPTH];

  logic                    in_bad;
  logic [ADDR_W_WORDS-1:0] in_idx;
  logic                    take;
  logic                    acc_go;
  logic                    acc_err;
  logic                    acc_we;
  logic [ADDR_W_WORDS-1:0] acc_idx;
  logic [31:0]             acc_wd;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]              lat_be;
  logic [3:0]              acc_be;
`endif

  // Misaligned or beyond the RAM: complete immediately with an error
  assign in_bad = (bus.addr[1:0] != 2'b00) || ((bus.addr >> (ADDR_W_WORDS + 2)) != 32'd0);
  assign in_idx = bus.addr[ADDR_W_WORDS+1:2];
  assign take   = (state == IDLE) && bus.req;

  assign bus.rd   = rd_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_q;
  assign bus.ack  = (state == DONE);

  // Next state, wait counter, and the access performed on the edge entering DONE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_go    = 1'b0;
    acc_err   = 1'b0;
    acc_we    = lat_we;
    acc_idx   = lat_idx;
    acc_wd    = lat_wd;
`ifdef DMEM_BYTE_EN_EN
    acc_be    = lat_be;
`endif
    case (state)
      IDLE: begin
        if (bus.req) begin
          // Zero-wait accesses commit straight from the bus inputs
          acc_we  = bus.we;
          acc_idx = in_idx;
          acc_wd  = bus.wd;
`ifdef DMEM_BYTE_EN_EN
          acc_be  = bus.be;
`endif
          if (in_bad) begin
            state_nxt = DONE;
            acc_err   = 1'b1;
          end else if (WAIT_STATES == 0) begin
            state_nxt = DONE;
            acc_go    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = DONE;
          acc_go    = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, latched request and completion outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_we  <= 1'b0;
      lat_idx <= '0;
      lat_wd  <= '0;
`ifdef DMEM_BYTE_EN_EN
      lat_be  <= '0;
`endif
      rd_q    <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy_q <= (state_nxt != IDLE);
      if (take) begin
        lat_we  <= bus.we;
        lat_idx <= in_idx;
        lat_wd  <= bus.wd;
`ifdef DMEM_BYTE_EN_EN
        lat_be  <= bus.be;
`endif
      end
      if (acc_err) begin
        rd_q  <= '0;
        err_q <= 1'b1;
      end else if (acc_go) begin
        err_q <= 1'b0;
        if (!acc_we) rd_q <= mem[acc_idx];
      end
    end
  end

  // RAM write port; contents survive reset and nothing commits while reset is held
  always_ff @(posedge clk) begin
    if (acc_go && acc_we && rst) begin
`ifdef DMEM_BYTE_EN_EN
      for (int i = 0; i < 4; i++)
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wd[8*i +: 8];
`else
      mem[acc_idx] <= acc_wd;
`endif
    end
  end
endmodule
